trainled2_chain_ctrl: RTL and testbench

//   Frame sequencer that drives the serial din of a daisy chain of TrainLED2 nodes.

---
 rtl/trainled2_pkg.sv | 17 +
 rtl/trainled2_chain_ctrl_if.sv | 9 +
 rtl/trainled2_bit_enc.sv | 25 ++
 rtl/trainled2_chain_ctrl.sv | 133 +++++++++++++
 tb/tb_trainled2_chain_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/trainled2_pkg.sv
// trainled2_pkg: shared types, pixel layout and default timing for the TrainLED2 chain sequencer.
package trainled2_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2, GAP = 2'd3} state_e;
    localparam int PIX_W = 24;
    localparam int LED1_MSB = 23;
    localparam int LED1_LSB = 16;
    localparam int LED2_MSB = 15;
    localparam int LED2_LSB = 8;
    localparam int LED3_MSB = 7;
    localparam int LED3_LSB = 0;
    localparam int DEF_NUM_NODES = 8;
    localparam int DEF_T_BIT = 12;
    localparam int DEF_T_HI0 = 3;
    localparam int DEF_T_HI1 = 8;
    localparam int DEF_T_LATCH = 64;
    typedef logic [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/trainled2_chain_ctrl_if.sv
// trainled2_chain_ctrl_if: valid/ready pixel stream from the host into the chain sequencer.
interface trainled2_chain_ctrl_if;
    import trainled2_pkg::*;
    pixel_t pix_data;
    logic   pix_valid;
    logic   pix_ready;
    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/trainled2_bit_enc.sv
// trainled2_bit_enc: pulse-width encoder for one bit cell; owns the cell counter.
module trainled2_bit_enc #(
    parameter int T_BIT = 12,
    parameter int T_HI0 = 3,
    parameter int T_HI1 = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_val,
    input  logic go,
    output logic dout,
    output logic cell_done
);
    localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last;
    assign last = cnt_q == CW'(T_BIT - 1);
    assign cell_done = go & last;
    assign dout = go & (cnt_q < CW'(bit_val ? T_HI1 : T_HI0));
    always_comb cnt_d = go ? (last ? '0 : cnt_q + 1'b1) : '0;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/trainled2_chain_ctrl.sv
// trainled2_chain_ctrl: frame sequencer driving pulse-width-coded pixels into a TrainLED2 chain.
// One pixel can be prefetched while the previous one shifts; a frame ends with a low latch gap.
module trainled2_chain_ctrl
    import trainled2_pkg::*;
#(
    parameter int NUM_NODES = DEF_NUM_NODES,
    parameter int T_BIT = DEF_T_BIT,
    parameter int T_HI0 = DEF_T_HI0,
    parameter int T_HI1 = DEF_T_HI1,
    parameter int T_LATCH = DEF_T_LATCH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    trainled2_chain_ctrl_if.slave pix,
    output logic dout,
    output logic busy,
    output logic frame_done,
    output logic underrun
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_FETCH = 2'(FETCH);
    localparam logic [1:0] S_SEND = 2'(SEND);
    localparam logic [1:0] S_GAP = 2'(GAP);
    localparam int GW = $clog2(T_LATCH + 1);

    logic [1:0] state_q, state_d;
    pixel_t hold_q, hold_d, shift_q, shift_d;
    logic full_q, full_d, done_q, done_d, uflow_q, uflow_d;
    logic [7:0] node_q, node_d, acc_q, acc_d;
    logic [4:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic xfer, avail, cell_done, last_bit, gap_end;

    assign busy = state_q != S_IDLE;
    assign pix.pix_ready = busy & ~full_q & (acc_q < 8'(NUM_NODES));
    assign xfer = pix.pix_valid & pix.pix_ready;
    // A pixel arriving during FETCH flows straight into the shifter, so it counts as available.
    assign avail = full_q | xfer;
    assign underrun = (state_q == S_FETCH) & ~avail & (node_q != '0);
    assign last_bit = cell_done & (bit_q == 5'(PIX_W - 1));
    assign gap_end = (state_q == S_GAP) & (gap_q == GW'(T_LATCH - 1));
    assign frame_done = done_q;

    trainled2_bit_enc #(.T_BIT(T_BIT), .T_HI0(T_HI0), .T_HI1(T_HI1)) u_enc (
        .clk(clk),
        .rst(rst),
        .bit_val(shift_q[PIX_W-1]),
        .go(state_q == S_SEND),
        .dout(dout),
        .cell_done(cell_done)
    );

    always_comb begin
        state_d = state_q;
        hold_d = hold_q;
        shift_d = shift_q;
        full_d = full_q;
        node_d = node_q;
        acc_d = acc_q + 8'(xfer);
        bit_d = bit_q;
        gap_d = gap_q;
        uflow_d = uflow_q;
        done_d = 1'b0;
        if (xfer && state_q != S_FETCH) begin
            hold_d = pix.pix_data;
            full_d = 1'b1;
        end
        case (state_q)
            S_IDLE: state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (avail) begin
                    shift_d = full_q ? hold_q : pix.pix_data;
                    full_d = 1'b0;
                    bit_d = '0;
                    state_d = S_SEND;
                end else if (node_q != '0) begin
                    uflow_d = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_SEND: begin
                if (cell_done) begin
                    shift_d = shift_q << 1;
                    bit_d = bit_q + 5'd1;
                end
                if (last_bit) begin
                    node_d = node_q + 8'd1;
                    state_d = (node_d == 8'(NUM_NODES)) ? S_GAP : S_FETCH;
                end
            end
            default: begin
                gap_d = gap_q + 1'b1;
                if (gap_end) begin
                    state_d = S_IDLE;
                    done_d = ~uflow_q;
                    node_d = '0;
                    acc_d = '0;
                    bit_d = '0;
                    gap_d = '0;
                    full_d = 1'b0;
                    uflow_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q <= '0;
            shift_q <= '0;
            full_q <= 1'b0;
            node_q <= '0;
            acc_q <= '0;
            bit_q <= '0;
            gap_q <= '0;
            uflow_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            shift_q <= shift_d;
            full_q <= full_d;
            node_q <= node_d;
            acc_q <= acc_d;
            bit_q <= bit_d;
            gap_q <= gap_d;
            uflow_q <= uflow_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_trainled2_chain_ctrl.sv
// tb_trainled2_chain_ctrl: directed and randomized frames checked against a cycle-arithmetic waveform model.
module tb_trainled2_chain_ctrl;
    import trainled2_pkg::*;
    localparam int NN = 2;
    localparam int TB = DEF_T_BIT;
    localparam int H0 = DEF_T_HI0;
    localparam int H1 = DEF_T_HI1;
    localparam int TL = DEF_T_LATCH;
    localparam int PER = 24 * TB + 1;
    localparam int FRAME = 1 + NN * PER + TL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic dout, busy, frame_done, underrun;
    int checks = 0;
    int errors = 0;
    pixel_t feed_q[$];
    pixel_t px[NN];
    logic wave_q[$];
    int kf = 0;
    int hold_h = 0;
    int thr = 100;
    int acc_frame = 0;
    int rdy_over = 0;

    trainled2_chain_ctrl_if pif ();

    trainled2_chain_ctrl #(.NUM_NODES(NN), .T_BIT(TB), .T_HI0(H0), .T_HI1(H1), .T_LATCH(TL)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pix(pif),
        .dout(dout),
        .busy(busy),
        .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        pif.pix_valid = feed_q.size() > 0 && kf >= hold_h && (acc_frame == 0 || $urandom_range(0, 99) < thr);
        pif.pix_data = feed_q.size() > 0 ? feed_q[0] : '0;
    endtask

    task automatic tick();
        logic x;
        x = pif.pix_valid & pif.pix_ready;
        if (pif.pix_ready && acc_frame >= NN) rdy_over++;
        @(posedge clk);
        #1;
        kf++;
        if (x) begin
            void'(feed_q.pop_front());
            acc_frame++;
        end
        drive();
    endtask

    // Expected dout j cycles after the start cycle, for an unstalled frame of nsent pixels.
    function automatic logic exp_dout(input int j, input int nsent);
        int n, r;
        if (j < 1) return 1'b0;
        n = (j - 1) / PER;
        r = (j - 1) % PER;
        if (n >= nsent || r == 0) return 1'b0;
        return ((r - 1) % TB) < (px[n][23 - (r - 1) / TB] ? H1 : H0);
    endfunction

    // Recover bits from captured high-pulse widths and count disagreements with the sent pixels.
    function automatic int decode_errs(input int nsent);
        int run, idx, errs;
        logic b;
        run = 0;
        idx = 0;
        errs = 0;
        foreach (wave_q[i]) begin
            if (wave_q[i]) run++;
            else if (run > 0) begin
                if (idx >= nsent * 24) errs++;
                else begin
                    b = px[idx / 24][23 - idx % 24];
                    if (run != (b ? H1 : H0)) errs++;
                end
                idx++;
                run = 0;
            end
        end
        return errs + ((idx != nsent * 24) ? 1 : 0);
    endfunction

    task automatic run_frame(input int h, input int t, input int sp1, input int sp2,
                             output int mism, output int done_at, output int fall_at,
                             output int uf_n, output int uf_at);
        int nsent, shift;
        nsent = feed_q.size() < NN ? feed_q.size() : NN;
        for (int i = 0; i < NN; i++) px[i] = i < nsent ? feed_q[i] : '0;
        hold_h = h;
        thr = t;
        kf = 0;
        acc_frame = 0;
        rdy_over = 0;
        wave_q.delete();
        mism = 0;
        done_at = -1;
        fall_at = -1;
        uf_n = 0;
        uf_at = -1;
        shift = (h > 1 ? h : 1) - 1;
        drive();
        for (int k = 0; k < 4000 && fall_at < 0; k++) begin
            start = (k == 0 || k == sp1 || k == sp2);
            if (dout !== exp_dout(k - shift, nsent)) mism++;
            wave_q.push_back(dout);
            if (frame_done) done_at = k;
            if (underrun) begin
                uf_n++;
                if (uf_at < 0) uf_at = k;
            end
            if (k > 0 && !busy) fall_at = k;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int mism, done_at, fall_at, uf_n, uf_at, busy_n;
        pif.pix_valid = 1'b0;
        pif.pix_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", pif.pix_ready, 0);

        feed_q = '{24'hFF0000, 24'h000001};
        run_frame(0, 100, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
        check("t1_wave", mism, 0);
        check("t1_decode", decode_errs(2), 0);
        check("t1_done_cycle", done_at, FRAME);
        check("t1_busy_fall", fall_at, FRAME);
        check("t1_underrun", uf_n, 0);
        check("t1_accepts", acc_frame, NN);
        check("t1_ready_over", rdy_over, 0);
        repeat (5) tick();

        feed_q = '{pixel_t'($urandom), pixel_t'($urandom)};
        run_frame(501, 100, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
        check("t2_wave", mism, 0);
        check("t2_done_cycle", done_at, FRAME + 500);
        check("t2_busy_fall", fall_at, FRAME + 500);
        check("t2_underrun", uf_n, 0);
        repeat (5) tick();

        feed_q = '{pixel_t'($urandom)};
        run_frame(0, 100, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
        check("t3_wave", mism, 0);
        check("t3_underrun_n", uf_n, 1);
        check("t3_underrun_at", uf_at, 1 + PER);
        check("t3_busy_fall", fall_at, 1 + PER + 1 + TL);
        check("t3_no_done", done_at, -1);
        repeat (5) tick();

        feed_q = '{pixel_t'($urandom), pixel_t'($urandom)};
        run_frame(0, 100, 100, FRAME - 1, mism, done_at, fall_at, uf_n, uf_at);
        check("t4_wave", mism, 0);
        check("t4_done_cycle", done_at, FRAME);
        check("t4_busy_fall", fall_at, FRAME);
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_n++;
            tick();
        end
        check("t4_no_restart", busy_n, 0);
        feed_q = '{pixel_t'($urandom), pixel_t'($urandom)};
        run_frame(0, 100, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
        check("t4_new_wave", mism, 0);
        check("t4_new_done", done_at, FRAME);
        repeat (5) tick();

        feed_q = '{24'h800000, pixel_t'($urandom)};
        kf = 0;
        acc_frame = 0;
        hold_h = 0;
        thr = 100;
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_pre_dout", dout, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_dout", dout, 0);
        check("t5_busy", busy, 0);
        check("t5_done", frame_done, 0);
        check("t5_underrun", underrun, 0);
        check("t5_ready", pif.pix_ready, 0);
        feed_q.delete();
        drive();
        repeat (3) tick();
        feed_q = '{pixel_t'($urandom), pixel_t'($urandom)};
        run_frame(0, 100, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
        check("t5_clean_wave", mism, 0);
        check("t5_clean_done", done_at, FRAME);
        repeat (5) tick();

        for (int f = 0; f < 4; f++) begin
            feed_q = '{pixel_t'($urandom), pixel_t'($urandom), pixel_t'($urandom)};
            run_frame(0, 30, -1, -1, mism, done_at, fall_at, uf_n, uf_at);
            check("t6_wave", mism, 0);
            check("t6_decode", decode_errs(NN), 0);
            check("t6_done_cycle", done_at, FRAME);
            check("t6_accepts", acc_frame, NN);
            check("t6_ready_over", rdy_over, 0);
            feed_q.delete();
            drive();
            repeat (3) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
